cla_slice_seq_ctrl: RTL
=======================

Name: cla_slice_seq_ctrl

Overview:
Sequencer that computes a WIDTH-bit add or subtract by time-multiplexing one SLICE-bit carry-lookahead slice over WIDTH/SLICE clock cycles, least significant slice first.
- Holds the operand and result registers, the inter-slice carry register and the slice index.
- Uses valid/ready handshakes on both sides.
- Sits between the ALU issue logic and the shared lookahead adder slice, so wide additions can reuse the narrow datapath.

Parameters:
WIDTH, 32, total operand width; must be a multiple of SLICE and at least SLICE
SLICE, 8, bits processed per cycle (lookahead slice width)
NSLICE, WIDTH/SLICE, derived local; number of RUN cycles

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (ignored when sub=1)
sub  in  1  1: compute a-b
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of bit WIDTH-1
ovf  out  1  signed overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, slice index=0, carry register=0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 once released.
  - Reset mid-RUN or in DONE aborts the operation; the result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid&&in_ready at an edge, register a and b. If sub=1, register ~b.
  - Initial carry = sub ? 1 : cin.
  - idx=0, go to RUN.
- RUN, each edge:
  - Take slice k=idx: p[i]=A[i]^B[i], g[i]=A[i]&B[i].
  - Carry chain per lookahead: c[i+1]=g[i]|(p[i]&c[i]), c[0]=carry register.
  - Write sum bits [k*SLICE +: SLICE] = p^c.
  - Carry register <= group carry out, G|(P&c0).
  - If idx==NSLICE-1, go to DONE with cout=final carry, ovf=c[SLICE-1]^c[SLICE] of the top slice. Otherwise idx+1.
- DONE:
  - out_valid=1. sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, go to IDLE and out_valid drops next cycle.
- Latency: out_valid rises NSLICE edges after the accept edge (4 for defaults).
  - Minimum issue interval is NSLICE+2 cycles. There is no overlap: in_ready=0 throughout RUN and DONE, including the DONE cycle where out_ready=1.
- Input isolation: a, b, cin and sub changes after acceptance have no effect. in_valid outside IDLE is ignored, not queued.
- Partial sum bits of slices not yet processed are unspecified until out_valid. Only values while out_valid=1 are architectural.
- WIDTH==SLICE gives a single RUN cycle, latency 1.
- Arithmetic is modulo 2^WIDTH. For sub, cout=1 means no borrow (a>=b unsigned).
- The sum is not affected by out_ready in any state other than DONE.

Test Plan:
- Reset then idle: a=0x12345678, in_valid=0 -> out_valid stays 0, in_ready=1, sum=0.
- Add with full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> 4 edges after accept: sum=0x00000000, cout=1, ovf=0; in_ready low during RUN/DONE.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1. Then sub with a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Backpressure and isolation: a=0x0000FF00, b=0x00000100, cin=1, out_ready=0 for 5 cycles after out_valid. Change a and b and pulse in_valid during RUN -> sum=0x00010001 held constant. A single result is produced and in_ready returns 1 one cycle after out_ready handshake.
- Reset mid-operation: assert rst_n=0 at the second RUN edge -> out_valid=0, busy=0 immediately (asynchronous). The next request a=3, b=4 yields sum=7, unaffected by the stale carry.
- Back-to-back: two requests, out_ready=1 always -> results at accept+4 each. The second is accepted exactly 2 cycles after the first out_valid rises.

Source files
------------

// File: rtl/cla_slice_seq_ctrl_if.sv
// Request/response bundle for the sliced carry-lookahead add/sub sequencer.
// The issue side owns the request fields and out_ready; the sequencer owns the rest.
interface cla_slice_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_slice_seq_ctrl.sv
// WIDTH-bit add/sub built by time-multiplexing one SLICE-bit lookahead slice,
// least significant slice first, one slice per clock.
module cla_slice_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_slice_seq_ctrl_if.slave  io_bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_c, r_cout, r_ovf;

  logic [SLICE-1:0] w_sa, w_sb, w_p, w_g;
  logic [SLICE:0]   w_c;
  logic             w_gg, w_gp, w_gco, w_last;

  assign w_sa   = r_a[r_idx*SLICE +: SLICE];
  assign w_sb   = r_b[r_idx*SLICE +: SLICE];
  assign w_last = (r_idx == IW'(NSLICE - 1));

  // Per-bit carries feed the sum; group generate/propagate give the slice carry-out.
  always_comb begin
    w_p    = w_sa ^ w_sb;
    w_g    = w_sa & w_sb;
    w_c    = '0;
    w_c[0] = r_c;
    w_gg   = 1'b0;
    w_gp   = 1'b1;
    for (int i = 0; i < SLICE; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      w_gg     = w_g[i] | (w_p[i] & w_gg);
      w_gp     = w_gp & w_p[i];
    end
    w_gco = w_gg | (w_gp & r_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid) begin
            // Subtract as a + ~b + 1.
            r_a     <= io_bus.a;
            r_b     <= io_bus.sub ? ~io_bus.b : io_bus.b;
            r_c     <= io_bus.sub | io_bus.cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_idx*SLICE +: SLICE] <= w_p ^ w_c[SLICE-1:0];
          r_c <= w_gco;
          if (w_last) begin
            r_cout  <= w_gco;
            r_ovf   <= w_c[SLICE-1] ^ w_c[SLICE];
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = (r_state == S_IDLE);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.sum       = r_sum;
  assign io_bus.cout      = r_cout;
  assign io_bus.ovf       = r_ovf;
endmodule
